// File: rtl/fp_pkg.sv
// Shared definitions for the FP normalisation datapath: rounding modes,
// GRS bit positions and exponent helpers.
package fp_pkg;

    typedef enum logic [1:0] {
        RND_RNE = 2'd0,
        RND_RTZ = 2'd1,
        RND_RUP = 2'd2,
        RND_RDN = 2'd3
    } rnd_mode_e;

    localparam int GRS_G = 2;
    localparam int GRS_R = 1;
    localparam int GRS_S = 0;

    // All-ones biased exponent (inf/NaN encoding) for an exponent of the given width.
    function automatic logic [31:0] exp_all_ones(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_round_pipe_if.sv
// Upstream/downstream beat bus of the rounding stage; master drives operands
// and iReady, slave is the rounding pipe itself.
interface fp_round_pipe_if #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
);
    logic              iValid;
    logic              oReady;
    logic              iSign;
    logic [EXP_W-1:0]  iExp;
    logic [MANT_W:0]   iMant;
    logic [2:0]        iGRS;
    logic [1:0]        iMode;
    logic              oValid;
    logic              iReady;
    logic              oSign;
    logic [EXP_W-1:0]  oExp;
    logic [MANT_W:0]   oMant;
    logic              oCarry;
    logic              oOverflow;
    logic              oInexact;

    modport master (
        output iValid, iSign, iExp, iMant, iGRS, iMode, iReady,
        input  oReady, oValid, oSign, oExp, oMant, oCarry, oOverflow, oInexact
    );

    modport slave (
        input  iValid, iSign, iExp, iMant, iGRS, iMode, iReady,
        output oReady, oValid, oSign, oExp, oMant, oCarry, oOverflow, oInexact
    );
endinterface

// File: rtl/fp_round_pipe_round_inc.sv
// Rounding increment decision: whether the kept mantissa must be bumped by one
// ulp given the sign, its LSB, the discarded GRS bits and the rounding mode.
module round_inc
    import fp_pkg::*;
(
    input  logic      sign,
    input  logic      lsb,
    input  logic [2:0] grs,
    input  rnd_mode_e mode,
    output logic      inc
);

    // Mode-dependent increment; RNE breaks exact ties toward an even LSB.
    always_comb begin
        inc = 1'b0;
        case (mode)
            RND_RNE: inc = grs[GRS_G] & (grs[GRS_R] | grs[GRS_S] | lsb);
            RND_RTZ: inc = 1'b0;
            RND_RUP: inc = ~sign & (|grs);
            RND_RDN: inc = sign & (|grs);
            default: inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage rounding and post-normalisation pipe with valid/ready handshake,
// placed between the leading-zero normaliser and the result packer.
module fp_round_pipe
    import fp_pkg::*;
#(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    fp_round_pipe_if.slave   bus
);

    localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(exp_all_ones(EXP_W));

    logic              s1_valid_r;
    logic              s1_sign_r;
    logic [EXP_W-1:0]  s1_exp_r;
    logic [MANT_W:0]   s1_mant_r;
    logic              s1_inc_r;
    logic              s1_inexact_r;

    logic              s2_valid_r;
    logic              s2_sign_r;
    logic [EXP_W-1:0]  s2_exp_r;
    logic [MANT_W:0]   s2_mant_r;
    logic              s2_carry_r;
    logic              s2_ovf_r;
    logic              s2_inexact_r;

    logic              s2_load_s;
    logic              ready_s;
    logic              accept_s;
    logic              special_in_s;
    logic              inc_raw_s;
    logic [MANT_W+1:0] sum_s;
    logic [EXP_W-1:0]  exp_inc_s;
    logic [EXP_W-1:0]  nxt_exp_s;
    logic [MANT_W:0]   nxt_mant_s;
    logic              nxt_carry_s;
    logic              nxt_ovf_s;

    // No skid buffer: upstream ready follows downstream ready combinationally.
    assign s2_load_s    = ~s2_valid_r | bus.iReady;
    assign ready_s      = ~s1_valid_r | s2_load_s;
    assign accept_s     = bus.iValid & ready_s;
    assign special_in_s = (bus.iExp == EXP_MAX);

    round_inc u_round_inc (
        .sign (bus.iSign),
        .lsb  (bus.iMant[0]),
        .grs  (bus.iGRS),
        .mode (rnd_mode_e'(bus.iMode)),
        .inc  (inc_raw_s)
    );

    // Stage 1 occupancy.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s1_valid_r <= 1'b0;
        end else if (ready_s) begin
            s1_valid_r <= bus.iValid;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 1 operand capture; inf/NaN beats never round and never flag inexact.
    always_ff @(posedge iClk) begin
        if (accept_s) begin
            s1_sign_r    <= bus.iSign;
            s1_exp_r     <= bus.iExp;
            s1_mant_r    <= bus.iMant;
            s1_inc_r     <= inc_raw_s & ~special_in_s;
            s1_inexact_r <= (|bus.iGRS) & ~special_in_s;
        end
    end

    assign sum_s     = {1'b0, s1_mant_r} + (MANT_W+2)'(s1_inc_r);
    assign exp_inc_s = s1_exp_r + {{(EXP_W-1){1'b0}}, 1'b1};

    // Renormalise on carry-out; saturate to infinity when the exponent tops out.
    // Denormals cannot carry out of the hidden bit, so they keep their exponent.
    always_comb begin
        nxt_exp_s   = s1_exp_r;
        nxt_mant_s  = sum_s[MANT_W:0];
        nxt_carry_s = 1'b0;
        nxt_ovf_s   = 1'b0;
        if (sum_s[MANT_W+1]) begin
            nxt_carry_s = 1'b1;
            nxt_exp_s   = exp_inc_s;
            nxt_mant_s  = {1'b1, sum_s[MANT_W:1]};
            if (exp_inc_s == EXP_MAX) begin
                nxt_ovf_s  = 1'b1;
                nxt_mant_s = {1'b1, {MANT_W{1'b0}}};
            end else begin
                nxt_ovf_s  = 1'b0;
            end
        end else begin
            nxt_carry_s = 1'b0;
        end
    end

    // Stage 2 output registers; held while the downstream stalls.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s2_valid_r   <= 1'b0;
            s2_sign_r    <= 1'b0;
            s2_exp_r     <= '0;
            s2_mant_r    <= '0;
            s2_carry_r   <= 1'b0;
            s2_ovf_r     <= 1'b0;
            s2_inexact_r <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_sign_r    <= s1_sign_r;
                s2_exp_r     <= nxt_exp_s;
                s2_mant_r    <= nxt_mant_s;
                s2_carry_r   <= nxt_carry_s;
                s2_ovf_r     <= nxt_ovf_s;
                s2_inexact_r <= s1_inexact_r;
            end
        end
    end

    assign bus.oReady    = ready_s;
    assign bus.oValid    = s2_valid_r;
    assign bus.oSign     = s2_sign_r;
    assign bus.oExp      = s2_exp_r;
    assign bus.oMant     = s2_mant_r;
    assign bus.oCarry    = s2_carry_r;
    assign bus.oOverflow = s2_ovf_r;
    assign bus.oInexact  = s2_inexact_r;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Scoreboard bench for fp_round_pipe: expected beats are queued when the DUT
// accepts an input and compared in order when it emits an output.
module tb_fp_round_pipe;
    import fp_pkg::*;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic [2:0]  grs;
        logic [1:0]  mode;
    } in_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic        carry;
        logic        ovf;
        logic        inx;
    } out_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    out_t exp_q[$];

    fp_round_pipe_if #(.MANT_W(23), .EXP_W(8)) bus();

    fp_round_pipe #(.MANT_W(23), .EXP_W(8)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t read_out();
        return {bus.oSign, bus.oExp, bus.oMant, bus.oCarry, bus.oOverflow, bus.oInexact};
    endfunction

    // Reference rounding model working on whole-number mantissa arithmetic.
    function automatic out_t model(in_t b);
        out_t        r;
        logic        inc;
        logic [24:0] sum;
        logic [7:0]  e1;
        r = {b.sign, b.exp, b.mant, 3'b000};
        if (b.exp == 8'hFF) return r;
        case (b.mode)
            2'd0:    inc = b.grs[2] & (b.grs[1] | b.grs[0] | b.mant[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = ~b.sign & (|b.grs);
            default: inc = b.sign & (|b.grs);
        endcase
        sum   = {1'b0, b.mant} + {24'd0, inc};
        r.inx = |b.grs;
        if (sum[24]) begin
            e1      = b.exp + 8'd1;
            r.exp   = e1;
            r.mant  = 24'h800000;
            r.carry = 1'b1;
            r.ovf   = (e1 == 8'hFF);
        end else begin
            r.mant = sum[23:0];
        end
        return r;
    endfunction

    // One bus cycle: drive at negedge, sample handshake and outputs 1ns later.
    task automatic step(input logic v, input in_t b, input logic rdy,
                        output logic took, output logic emitted, output out_t o);
        @(negedge clk);
        bus.iValid = v;
        {bus.iSign, bus.iExp, bus.iMant, bus.iGRS, bus.iMode} = b;
        bus.iReady = rdy;
        #1;
        took    = v & bus.oReady;
        emitted = bus.oValid & rdy;
        o       = read_out();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (read_out() !== '0 || bus.oValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h valid=%b want=0", read_out(), bus.oValid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.oReady !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got=%b want=1", bus.oReady);
        end
        vectors++;
        if (bus.oValid !== 1'b0 || read_out() !== '0) begin
            miscompares++;
            $display("FAIL reset_release got=%h valid=%b want=0", read_out(), bus.oValid);
        end
    endtask

    task automatic test_directed();
        in_t  vin[11];
        out_t vexp[11];
        in_t  cur;
        out_t o, e;
        logic took, emitted;
        int   si = 0;
        int   got = 0;
        vin[0]  = {1'b0, 8'h80, 24'h800001, 3'b100, 2'd0}; vexp[0]  = {1'b0, 8'h80, 24'h800002, 3'b001};
        vin[1]  = {1'b0, 8'h80, 24'h800002, 3'b100, 2'd0}; vexp[1]  = {1'b0, 8'h80, 24'h800002, 3'b001};
        vin[2]  = {1'b0, 8'h7F, 24'hFFFFFF, 3'b110, 2'd0}; vexp[2]  = {1'b0, 8'h80, 24'h800000, 3'b101};
        vin[3]  = {1'b0, 8'hFE, 24'hFFFFFF, 3'b111, 2'd2}; vexp[3]  = {1'b0, 8'hFF, 24'h800000, 3'b111};
        vin[4]  = {1'b0, 8'hFE, 24'hFFFFFF, 3'b111, 2'd3}; vexp[4]  = {1'b0, 8'hFE, 24'hFFFFFF, 3'b001};
        vin[5]  = {1'b1, 8'h85, 24'hC00000, 3'b001, 2'd3}; vexp[5]  = {1'b1, 8'h85, 24'hC00001, 3'b001};
        vin[6]  = {1'b1, 8'h85, 24'hC00000, 3'b001, 2'd2}; vexp[6]  = {1'b1, 8'h85, 24'hC00000, 3'b001};
        vin[7]  = {1'b1, 8'h85, 24'hC00000, 3'b001, 2'd1}; vexp[7]  = {1'b1, 8'h85, 24'hC00000, 3'b001};
        vin[8]  = {1'b0, 8'hFF, 24'hC00001, 3'b111, 2'd0}; vexp[8]  = {1'b0, 8'hFF, 24'hC00001, 3'b000};
        vin[9]  = {1'b0, 8'h00, 24'h7FFFFF, 3'b100, 2'd0}; vexp[9]  = {1'b0, 8'h00, 24'h800000, 3'b001};
        vin[10] = {1'b1, 8'h40, 24'hA00000, 3'b000, 2'd3}; vexp[10] = {1'b1, 8'h40, 24'hA00000, 3'b000};
        for (int cyc = 0; cyc < 100 && got < 11; cyc++) begin
            cur = '0;
            if (si < 11) cur = vin[si];
            step(si < 11, cur, 1'b1, took, emitted, o);
            if (took) begin
                exp_q.push_back(vexp[si]);
                si++;
            end
            if (emitted) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL directed_spurious got=%h want=none", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        miscompares++;
                        $display("FAIL directed[%0d] got=%h want=%h", got, o, e);
                    end
                end
                got++;
            end
        end
        if (got < 11) begin
            vectors++;
            miscompares++;
            $display("FAIL directed_timeout got=%0d want=11", got);
        end
    endtask

    task automatic test_back_to_back();
        int   take_q[$];
        in_t  b;
        out_t o, e;
        logic took, emitted;
        int   si = 0;
        int   got = 0;
        int   t0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            b = {1'b0, 8'h20 + 8'(si), 24'h800000 | 24'(si * 3), 3'(si), 2'd0};
            step(si < 8, b, 1'b1, took, emitted, o);
            if (took) begin
                exp_q.push_back(model(b));
                take_q.push_back(cyc);
                si++;
            end
            if (emitted) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_spurious got=%h want=none", o);
                end else begin
                    e  = exp_q.pop_front();
                    t0 = take_q.pop_front();
                    if (o !== e) begin
                        miscompares++;
                        $display("FAIL b2b[%0d] got=%h want=%h", got, o, e);
                    end
                    vectors++;
                    if (cyc - t0 != 2) begin
                        miscompares++;
                        $display("FAIL b2b_latency got=%0d want=2", cyc - t0);
                    end
                end
                got++;
            end
        end
        vectors++;
        if (got < 8 || si != 8) begin
            miscompares++;
            $display("FAIL b2b_throughput got=%0d want=8", got);
        end
    endtask

    task automatic test_stream();
        in_t  b;
        out_t o, e, held;
        logic took, emitted, rdy;
        logic stalled = 1'b0;
        int   si = 0;
        int   got = 0;
        b = '0;
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            if (!took || cyc == 0) begin
                b.sign = 1'($urandom_range(0, 1));
                b.exp  = (si == 3) ? 8'hFF : 8'($urandom_range(1, 254));
                b.mant = (si == 5) ? 24'hFFFFFF : {1'b1, 23'($urandom)};
                b.grs  = 3'($urandom);
                b.mode = 2'($urandom);
            end
            rdy = 1'($urandom_range(0, 1));
            step(si < 10, b, rdy, took, emitted, o);
            if (stalled) begin
                vectors++;
                if (bus.oValid !== 1'b1 || o !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold got=%h want=%h", o, held);
                end
            end
            stalled = bus.oValid & ~rdy;
            held    = o;
            if (took) begin
                exp_q.push_back(model(b));
                si++;
            end
            if (emitted) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_spurious got=%h want=none", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        miscompares++;
                        $display("FAIL stream[%0d] got=%h want=%h", got, o, e);
                    end
                end
                got++;
            end
        end
        if (got < 10) begin
            vectors++;
            miscompares++;
            $display("FAIL stream_timeout got=%0d want=10", got);
        end
    endtask

    task automatic test_reset_flight();
        in_t  b;
        out_t o;
        logic took, emitted;
        int   si = 0;
        for (int cyc = 0; cyc < 20 && si < 2; cyc++) begin
            b = {1'b0, 8'h50, 24'h900000 | 24'(si), 3'b101, 2'd0};
            step(1'b1, b, 1'b0, took, emitted, o);
            if (took) si++;
        end
        step(1'b0, '0, 1'b0, took, emitted, o);
        vectors++;
        if (si != 2 || bus.oValid !== 1'b1 || bus.oReady !== 1'b0) begin
            miscompares++;
            $display("FAIL flight_fill got=%0d/%b/%b want=2/1/0", si, bus.oValid, bus.oReady);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.oValid !== 1'b0 || read_out() !== '0 || bus.oReady !== 1'b1) begin
            miscompares++;
            $display("FAIL flight_reset got=%b/%h/%b want=0/0/1", bus.oValid, read_out(), bus.oReady);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            step(1'b0, '0, 1'b1, took, emitted, o);
            vectors++;
            if (emitted) begin
                miscompares++;
                $display("FAIL flight_ghost got=%h want=none", o);
            end
        end
        vectors++;
        if (bus.oReady !== 1'b1) begin
            miscompares++;
            $display("FAIL flight_ready got=%b want=1", bus.oReady);
        end
    endtask

    initial begin
        bus.iValid = 1'b0;
        bus.iSign  = 1'b0;
        bus.iExp   = 8'h00;
        bus.iMant  = 24'h000000;
        bus.iGRS   = 3'b000;
        bus.iMode  = 2'd0;
        bus.iReady = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stream();
        test_reset_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_round_pipe.md
# fp_round_pipe

Parametrised, pipelined rounding and post-normalisation stage for the FP normalisation datapath. Accepts a sign, biased exponent, mantissa with hidden bit, and guard/round/sticky bits. Applies one of four IEEE-754 rounding modes, renormalises on mantissa carry-out, adjusts the exponent and flags overflow and inexact. Two register stages with a valid/ready handshake; sits between the leading-zero normaliser and the result packer.

## Interface
- `MANT_W`, default 23: stored fraction width. The mantissa bus is MANT_W+1 bits, with the hidden bit at the MSB.
- `EXP_W`, default 8: biased exponent width.
- `iClk`, in, 1: clock. All state updates on the rising edge.
- `iRst_n`, in, 1: reset, asynchronous, active-low.
- `iValid`, in, 1: input beat valid.
- `oReady`, out, 1: stage can accept an input beat.
- `iSign`, in, 1: operand sign.
- `iExp`, in, EXP_W: biased exponent.
- `iMant`, in, MANT_W+1: mantissa, hidden bit at [MANT_W].
- `iGRS`, in, 3: guard [2], round [1], sticky [0].
- `iMode`, in, 2: rounding mode. 0 = RNE, 1 = RTZ, 2 = RUP (toward +inf), 3 = RDN (toward -inf).
- `oValid`, out, 1: output beat valid.
- `iReady`, in, 1: downstream accepts an output beat.
- `oSign`, out, 1: result sign.
- `oExp`, out, EXP_W: result biased exponent.
- `oMant`, out, MANT_W+1: result mantissa.
- `oCarry`, out, 1: rounding produced a carry-out and renormalisation occurred.
- `oOverflow`, out, 1: the exponent reached all-ones through the increment.
- `oInexact`, out, 1: GRS was nonzero on a rounded, non-special beat.

## Operation
- **Special input.** `iExp` is all-ones (inf/NaN): the beat passes through unchanged. Increment is 0; `oCarry`, `oOverflow` and `oInexact` are 0.
- **Stage 1.** Registers sign, exp, mant, a special flag, an inexact flag (`|iGRS`) and the increment decision `inc`, where L = `iMant[0]`:
  - RNE: inc = G & (R | S | L)
  - RTZ: inc = 0
  - RUP: inc = ~sign & (G | R | S)
  - RDN: inc = sign & (G | R | S)
- **Stage 2.** Computes sum = mant + inc at MANT_W+2 bits.
  - **No carry-out:** `oMant` = sum[MANT_W:0]; exp is unchanged.
  - **Carry-out:** `oMant` = {1'b1, sum[MANT_W:1]}, which equals 1000…0. The exponent increments and `oCarry` = 1.
  - **Overflow:** if the incremented exponent is all-ones, `oOverflow` = 1 and the result is infinity: exp all-ones, `oMant` = {1'b1, 0…}. A carry only occurs when rounding away from zero, so infinity is correct in every mode.
- **Zero / denormal.** Exponent 0 with hidden bit 0: rounding is applied identically. If the carry reaches bit MANT_W, the hidden bit becomes 1 and the exponent stays 0. Exponent adjustment for this case belongs to the packer; `oCarry` = 0 here.

## Timing
- Latency is 2 cycles from input acceptance (`iValid` & `oReady`) to `oValid`, when there is no back-pressure.
- Full throughput: 1 beat per cycle while `iReady` = 1.
- **Stage advance.** Stage 2 loads when it is empty or its beat is accepted (`oValid` & `iReady`). Stage 1 advances when stage 2 loads.
  - `oReady` = ~s1_valid | s1_advance. It is combinational from `iReady`; there is no skid buffer.
- **Stall.** While `oValid` & ~`iReady`, all output buses hold stable and no beat is dropped or duplicated.
- **Simultaneous events.** Accept and emit in the same cycle with both stages full: the pipeline shifts and occupancy stays at 2.
- **Reset.** Asserting `iRst_n` low, including mid-operation, immediately clears both valid bits; in-flight beats are discarded. All outputs reset to 0: `oValid`, `oSign`, `oExp`, `oMant`, `oCarry`, `oOverflow`, `oInexact`. `oReady` is 1 after reset.
- Data registers need not be reset beyond the output bus. Valid bits must be reset.

## Structure
- Shared package `fp_pkg` holds:
  - the rounding-mode constants RNE / RTZ / RUP / RDN
  - the GRS bit index constants
  - a function `exp_all_ones(EXP_W)`
- The natural sub-module is `round_inc`: a combinational increment decision from sign, L, GRS and mode, instantiated in stage 1.
- The adder and renormalise mux stay inline in stage 2.

## Test plan
All vectors use MANT_W = 23 and EXP_W = 8.
- **RNE tie to even.** Mant 24'h800001, GRS 100, exp 8'h80 → mant 24'h800002, exp 8'h80, carry 0, inexact 1. Mant 24'h800002, GRS 100 → mant 24'h800002, inexact 1.
- **Carry renorm.** Mant 24'hFFFFFF, GRS 110, RNE, exp 8'h7F → mant 24'h800000, exp 8'h80, carry 1, overflow 0.
- **Overflow.** Mant 24'hFFFFFF, GRS 111, RUP, sign 0, exp 8'hFE → exp 8'hFF, mant 24'h800000, overflow 1. The same input in RDN → unchanged, inexact 1.
- **Directed modes.** Mant 24'hC00000, GRS 001, sign 1: RDN gives 24'hC00001; RUP gives 24'hC00000; RTZ gives 24'hC00000.
- **Passthrough.** Exp 8'hFF, mant 24'hC00001, GRS 111, RNE → output identical to input, all flags 0.
- **Handshake and reset.**
  - Stream 10 beats with `iReady` toggled randomly: all 10 emerge in order, unchanged under stall.
  - Pull `iRst_n` low with 2 beats in flight: `oValid` drops at once, nothing emerges after release, and `oReady` = 1.
